// File: rtl/max7219_pkg.sv
// Shared constants and types for the MAX7219 emulator: register map,
// image characters and the per-row string type.
package max7219_pkg;

   localparam logic [3:0] ADDR_NOOP      = 4'h0;
   localparam logic [3:0] ADDR_DIG0      = 4'h1;
   localparam logic [3:0] ADDR_DIG1      = 4'h2;
   localparam logic [3:0] ADDR_DIG2      = 4'h3;
   localparam logic [3:0] ADDR_DIG3      = 4'h4;
   localparam logic [3:0] ADDR_DIG4      = 4'h5;
   localparam logic [3:0] ADDR_DIG5      = 4'h6;
   localparam logic [3:0] ADDR_DIG6      = 4'h7;
   localparam logic [3:0] ADDR_DIG7      = 4'h8;
   localparam logic [3:0] ADDR_DECODE    = 4'h9;
   localparam logic [3:0] ADDR_INTENSITY = 4'hA;
   localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
   localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
   localparam logic [3:0] ADDR_TEST      = 4'hF;

   localparam logic [7:0] CHAR_ON  = 8'h58;   // "X"
   localparam logic [7:0] CHAR_OFF = 8'h2E;   // "."

   // Eight ASCII characters, leftmost character in bits [63:56].
   typedef logic [63:0] row_str_t;

endpackage

// File: rtl/max7219_sync_edge.sv
// Two-flop synchroniser for one asynchronous bus pin, plus a third flop
// used only to detect rising and falling edges of the synchronised level.
module max7219_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [2:0] pipe_q, pipe_d;

   // Shift the pad value through the synchroniser and edge-detect stage
   always_comb begin
      pipe_d = {pipe_q[1:0], i_async};
   end

   // Pipeline register, cleared synchronously
   always_ff @(posedge clk) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= pipe_d;
   end

   assign o_sync = pipe_q[1];
   assign o_rise =  pipe_q[1] & ~pipe_q[2];
   assign o_fall = ~pipe_q[1] &  pipe_q[2];

endmodule

// File: rtl/max7219_emulator.sv
// Behavioural model of one MAX7219 driving an 8x8 matrix. Samples the
// serial bus in the clk domain, decodes 16-bit writes on LOAD rising and
// keeps an ASCII image of the matrix in s_matrix_char.
module max7219_emulator
   import max7219_pkg::*;
#(
   parameter int G_MATRIX_I = 0,
   parameter bit G_VERBOSE  = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_max7219_clk,
   input  logic i_max7219_din,
   input  logic i_max7219_load,
   output logic o_max7219_dout,
   output logic o_matrix_char_val
);

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic din_lvl, din_rise, din_fall;
   logic load_lvl, load_rise, load_fall;

   max7219_sync_edge u_sync_sclk (.clk(clk), .rst_n(rst_n), .i_async(i_max7219_clk),
                                  .o_sync(sclk_lvl), .o_rise(sclk_rise), .o_fall(sclk_fall));
   max7219_sync_edge u_sync_din  (.clk(clk), .rst_n(rst_n), .i_async(i_max7219_din),
                                  .o_sync(din_lvl), .o_rise(din_rise), .o_fall(din_fall));
   max7219_sync_edge u_sync_load (.clk(clk), .rst_n(rst_n), .i_async(i_max7219_load),
                                  .o_sync(load_lvl), .o_rise(load_rise), .o_fall(load_fall));

   logic [15:0] shreg_q, shreg_d;
   logic        dout_q, dout_d;
   logic [7:0]  digit_q [8];
   logic [7:0]  digit_d [8];
   logic [7:0]  decode_q, decode_d;
   logic [3:0]  intensity_q, intensity_d;
   logic [2:0]  scan_limit_q, scan_limit_d;
   logic        shutdown_n_q, shutdown_n_d;
   logic        disp_test_q, disp_test_d;
   row_str_t    matrix_char_q [8];
   row_str_t    matrix_char_d [8];
   logic        char_val_q, char_val_d;
   logic        wr_valid;
   logic        lit;
   logic [3:0]  addr;
   logic [7:0]  data;

   assign addr = shreg_q[11:8];
   assign data = shreg_q[7:0];

   // Shift/DOUT handling, register decode, and image rebuild from the
   // post-write register values so the new image lands together with them
   always_comb begin
      shreg_d      = shreg_q;
      dout_d       = dout_q;
      digit_d      = digit_q;
      decode_d     = decode_q;
      intensity_d  = intensity_q;
      scan_limit_d = scan_limit_q;
      shutdown_n_d = shutdown_n_q;
      disp_test_d  = disp_test_q;
      wr_valid     = 1'b0;
      lit          = 1'b0;

      if (sclk_rise) shreg_d = {shreg_q[14:0], din_lvl};
      if (sclk_fall) dout_d  = shreg_q[15];

      // Decode uses shreg_q, i.e. the value before any shift this cycle
      if (load_rise) begin
         wr_valid = 1'b1;
         case (addr)
            ADDR_DIG0, ADDR_DIG1, ADDR_DIG2, ADDR_DIG3,
            ADDR_DIG4, ADDR_DIG5, ADDR_DIG6, ADDR_DIG7:
                            digit_d[addr - 4'd1] = data;
            ADDR_DECODE:    decode_d     = data;
            ADDR_INTENSITY: intensity_d  = data[3:0];
            ADDR_SCANLIM:   scan_limit_d = data[2:0];
            ADDR_SHUTDOWN:  shutdown_n_d = data[0];
            ADDR_TEST:      disp_test_d  = data[0];
            default:        wr_valid     = 1'b0;   // no-op and 0xD/0xE
         endcase
      end

      matrix_char_d = matrix_char_q;
      if (wr_valid) begin
         for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
               lit = disp_test_d |
                     (shutdown_n_d & (3'(r) <= scan_limit_d) & digit_d[r][c]);
               matrix_char_d[r][8*c +: 8] = lit ? CHAR_ON : CHAR_OFF;
            end
         end
      end
      char_val_d = wr_valid;
   end

   // State registers with synchronous reset to power-up (shutdown) state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg_q       <= '0;
         dout_q        <= 1'b0;
         digit_q       <= '{default: '0};
         decode_q      <= '0;
         intensity_q   <= '0;
         scan_limit_q  <= '0;
         shutdown_n_q  <= 1'b0;
         disp_test_q   <= 1'b0;
         matrix_char_q <= '{default: {8{CHAR_OFF}}};
         char_val_q    <= 1'b0;
      end else begin
         shreg_q       <= shreg_d;
         dout_q        <= dout_d;
         digit_q       <= digit_d;
         decode_q      <= decode_d;
         intensity_q   <= intensity_d;
         scan_limit_q  <= scan_limit_d;
         shutdown_n_q  <= shutdown_n_d;
         disp_test_q   <= disp_test_d;
         matrix_char_q <= matrix_char_d;
         char_val_q    <= char_val_d;
      end
   end

   row_str_t s_matrix_char [8];
   assign s_matrix_char     = matrix_char_q;
   assign o_max7219_dout    = dout_q;
   assign o_matrix_char_val = char_val_q;

   // Decode and intensity are stored for visibility only; spare sync outputs
   logic unused_bits;
   assign unused_bits = ^{sclk_lvl, din_rise, din_fall, load_lvl, load_fall,
                          decode_q, intensity_q};

`ifndef SYNTHESIS
   // Trace every LOAD-latched register write
   always @(posedge clk) begin
      if (G_VERBOSE && rst_n && load_rise)
         $display("MAX7219[%0d] reg 0x%h <= 0x%h", G_MATRIX_I, addr, data);
   end
`endif

endmodule

// File: tb/tb_max7219_emulator.sv
// Bench for a two-device cascade of max7219_emulator, checked against a
// chain-level reference model of the register map and matrix image.
module tb_max7219_emulator;

   logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, din = 1'b0, load = 1'b0;
   logic dout0, dout1, val0, val1;

   always #5 clk = ~clk;

   max7219_emulator #(.G_MATRIX_I(0), .G_VERBOSE(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_max7219_clk(sclk), .i_max7219_din(din),
      .i_max7219_load(load), .o_max7219_dout(dout0), .o_matrix_char_val(val0));

   max7219_emulator #(.G_MATRIX_I(1), .G_VERBOSE(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_max7219_clk(sclk), .i_max7219_din(dout0),
      .i_max7219_load(load), .o_max7219_dout(dout1), .o_matrix_char_val(val1));

   int n_vec = 0, n_err = 0;
   int pulse_cnt [2] = '{0, 0};

   // Count cycles with the refresh strobe high, sampled on the idle edge
   always @(negedge clk) begin
      if (val0) pulse_cnt[0]++;
      if (val1) pulse_cnt[1]++;
   end

   // ---------------- reference model ----------------
   logic [31:0] chain_m;          // {dev1 shreg, dev0 shreg}
   logic [7:0]  dig_m  [2][8];
   int          scan_m [2];
   bit          shut_m [2];
   bit          test_m [2];
   int          exp_pulse [2] = '{0, 0};

   task automatic model_reset();
      chain_m = '0;
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 8; r++) dig_m[d][r] = '0;
         scan_m[d] = 0; shut_m[d] = 0; test_m[d] = 0;
      end
   endtask

   task automatic model_write(input int dev, input logic [15:0] w);
      int a;
      a = int'(w[11:8]);
      if (a >= 1 && a <= 8)  dig_m[dev][a-1] = w[7:0];
      else if (a == 11)      scan_m[dev] = int'(w[2:0]);
      else if (a == 12)      shut_m[dev] = w[0];
      else if (a == 15)      test_m[dev] = w[0];
      if (a >= 1 && a <= 12 || a == 15) exp_pulse[dev]++;
   endtask

   function automatic logic [63:0] row_exp(input int dev, input int r);
      string s = "";
      logic [63:0] v = '0;
      for (int c = 7; c >= 0; c--) begin
         if (test_m[dev] || (shut_m[dev] && r <= scan_m[dev] && dig_m[dev][r][c]))
            s = {s, "X"};
         else
            s = {s, "."};
      end
      for (int i = 0; i < 8; i++) v = {v[55:0], s[i]};
      return v;
   endfunction

   function automatic logic [63:0] row_got(input int dev, input int r);
      return (dev == 0) ? u_dut0.s_matrix_char[r] : u_dut1.s_matrix_char[r];
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 8; r++)
            chk($sformatf("%s dev%0d row%0d", tag, d, r), row_got(d, r), row_exp(d, r));
         chk($sformatf("%s dev%0d pulses", tag, d), 64'(pulse_cnt[d]), 64'(exp_pulse[d]));
      end
      chk({tag, " dout0"}, 64'(dout0), 64'(chain_m[15]));
      chk({tag, " dout1"}, 64'(dout1), 64'(chain_m[31]));
   endtask

   // ---------------- bus driving ----------------
   task automatic shift_bit(input logic b);
      din = b;
      repeat (8) @(posedge clk);
      sclk = 1'b1;
      repeat (8) @(posedge clk);
      sclk = 1'b0;
      chain_m = {chain_m[30:0], b};
   endtask

   task automatic shift_bits(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) shift_bit(v[i]);
   endtask

   task automatic do_load();
      repeat (8) @(posedge clk);
      load = 1'b1;
      repeat (8) @(posedge clk);
      load = 1'b0;
      repeat (8) @(posedge clk);
      model_write(1, chain_m[31:16]);
      model_write(0, chain_m[15:0]);
   endtask

   task automatic write_word(input logic [15:0] w, input string tag);
      shift_bits({48'h0, w}, 16);
      do_load();
      check_all(tag);
   endtask

   // LOAD and a serial-clock rise reach the device in the same cycle
   task automatic load_with_clk(input logic b);
      din = b;
      repeat (8) @(posedge clk);
      sclk = 1'b1;
      load = 1'b1;
      model_write(1, chain_m[31:16]);
      model_write(0, chain_m[15:0]);
      chain_m = {chain_m[30:0], b};
      repeat (8) @(posedge clk);
      sclk = 1'b0;
      load = 1'b0;
      repeat (8) @(posedge clk);
   endtask

   initial begin
      model_reset();
      repeat (5) @(posedge clk);
      check_all("reset");
      chk("reset val0", 64'(val0), 64'(0));
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      write_word(16'h0C01, "enable");
      write_word(16'h0B07, "scan7");
      write_word(16'h01AA, "dig0 AA");
      chk("dig0 string", row_got(0, 0), "X.X.X.X.");
      write_word(16'h0F01, "test on");
      chk("test row3", row_got(0, 3), "XXXXXXXX");
      write_word(16'h0F00, "test off");
      write_word(16'h0281, "dig1 81");
      write_word(16'h0C00, "shutdown");
      chk("shutdown row1", row_got(0, 1), "........");
      write_word(16'h0C01, "wake");
      chk("wake row1", row_got(0, 1), "X......X");
      write_word(16'h0B02, "scan2");
      write_word(16'h08FF, "dig7 FF");
      chk("beyond scan row7", row_got(0, 7), "........");
      write_word(16'h0B07, "scan7 again");
      chk("scan7 row7", row_got(0, 7), "XXXXXXXX");

      // Cascade: dev1 gets 0x0103, dev0 gets a no-op
      shift_bits({32'h0, 16'h0103, 16'h0000}, 32);
      do_load();
      check_all("cascade");
      chk("cascade dev1 row0", row_got(1, 0), "......XX");

      write_word(16'h0000, "noop");
      write_word(16'h0D55, "addr D");

      // Write collides with a shift edge: pre-shift value must be used
      shift_bits({48'h0, 16'h0155}, 16);
      load_with_clk(1'b1);
      check_all("load+clk");

      // Randomised frames of varying length (short, exact, overlong)
      for (int k = 0; k < 40; k++) begin
         logic [63:0] v;
         int n;
         v = {$urandom, $urandom};
         if (k % 3 == 0) v[11:8] = 4'hC;   // keep the display awake often
         n = $urandom_range(4, 40);
         shift_bits(v, n);
         do_load();
         check_all($sformatf("rand%0d", k));
      end

      // Reset in the middle of a frame
      shift_bits({32'h0, $urandom}, 7);
      rst_n = 1'b0;
      model_reset();
      repeat (4) @(posedge clk);
      check_all("mid reset");
      chk("mid reset val1", 64'(val1), 64'(0));
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      write_word(16'h0C01, "post reset en");
      write_word(16'h01FF, "post reset dig0");
      chk("post reset row0", row_got(0, 0), "XXXXXXXX");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
